// File: rtl/mem_exec_unit.sv
// mem_exec_unit: LW/SW execution unit between the issue queue, data memory
// and the CDB arbiter. One access in flight at a time.
module mem_exec_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueque_ready,
  input  logic [DATA_W-1:0] issueque_rs_data,
  input  logic [DATA_W-1:0] issueque_rt_data,
  input  logic [DATA_W-1:0] issueque_imm,
  input  logic [TAG_W-1:0]  issueque_rd_tag,
  input  logic              issueque_opcode,
  output logic              issueblk_done,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              cdb_req,
  output logic [TAG_W-1:0]  cdb_out_tag,
  output logic [DATA_W-1:0] cdb_out_data,
  input  logic              cdb_grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    CDB_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              req_d, we_d;
  logic [DATA_W-1:0] addr_d, wdata_d;
  logic              cdb_req_d;
  logic [TAG_W-1:0]  cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_d;
  logic              accept;

  // done is gated by reset so the queue never pops while the core is held
  assign accept        = reset & (state_q == IDLE) & issueque_ready;
  assign issueblk_done = accept;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    req_d      = dmem_req;
    we_d       = dmem_we;
    addr_d     = dmem_addr;
    wdata_d    = dmem_wdata;
    cdb_req_d  = cdb_req;
    cdb_tag_d  = cdb_out_tag;
    cdb_data_d = cdb_out_data;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = issueque_rs_data + issueque_imm;
          wdata_d = issueque_rt_data;
          tag_d   = issueque_rd_tag;
          we_d    = issueque_opcode;
          req_d   = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_req && dmem_ack) begin
          req_d = 1'b0;
          if (dmem_we) begin
            state_d = IDLE;
          end else begin
            cdb_data_d = dmem_rdata;
            cdb_tag_d  = tag_q;
            cdb_req_d  = 1'b1;
            state_d    = CDB_WAIT;
          end
        end
      end
      CDB_WAIT: begin
        if (cdb_req && cdb_grant) begin
          cdb_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        req_d     = 1'b0;
        cdb_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      cdb_req      <= 1'b0;
      cdb_out_tag  <= '0;
      cdb_out_data <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      cdb_req      <= cdb_req_d;
      cdb_out_tag  <= cdb_tag_d;
      cdb_out_data <= cdb_data_d;
    end
  end

endmodule
